task_scheduler: RTL and testbench
=================================

Name: task_scheduler

Overview:
- Dispatches a preloaded program image, held as DATA_DEPTH frames, to a 16-core array.
- The image is a sequence of tasks. Each task has a 3-frame header followed by body frames.
- The scheduler checks core availability, mask collisions, barrier flags and hold flags before launching a task.
- On launch it streams the task body to the selected cores, one frame per accepted cycle.
- It sits between program memory and the core array.

Parameters:
- DATA_DEPTH, 1024: number of frames in the program image.
- INSTR_SIZE, 16: instruction width in bits. Equals FRAME_SIZE.
- FRAME_SIZE, 16: frame width in bits.
- CORE_NUM, 16: number of cores. This is the mask width.
- BUS_TO_CORE, 16: width of the core data bus. Equals FRAME_SIZE.
- R0_DEPTH, 8: width of the task_id counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- prog_loading  in  1  high while the image is being written; scheduler is held idle.
- data_frames_in  in  DATA_DEPTH*FRAME_SIZE  packed image; frame i occupies bits [i*FRAME_SIZE +: FRAME_SIZE].
- core_ready  in  CORE_NUM  per-core ready (idle) flag.
- core_reading  in  1  cores accept the frame on the bus this cycle.
- frame_being_sent  out  1  frame_out is valid and accepted this cycle.
- frame_out  out  BUS_TO_CORE  current body frame.
- core_select  out  CORE_NUM  mask of the cores targeted by the current task.
- task_start  out  1  one-cycle pulse on launch.
- task_id  out  R0_DEPTH  launch counter; increments at each launch and wraps.
- sched_done  out  1  image exhausted.

Behaviour:
- Header layout, task starting at pointer P:
  - frame P bits[5:0] LEN: the task spans (LEN+1)*16 frames, header included.
  - frame P bit6 HOLD: the next task may not launch until every core of this task has completed.
  - frame P bit7 BARRIER: this task launches only when all CORE_NUM cores are available.
  - frame P bits[15:8]: reserved, ignored.
  - frame P+1 MASK: target cores.
  - frame P+2 WMASK: additional cores that must be available before launch.
- Core availability:
  - busy[i] is set at launch for every core in MASK.
  - busy[i] clears on a registered 0->1 edge of core_ready[i].
  - avail[i] = core_ready[i] & ~busy[i].
- Launch condition, all of the following:
  - (MASK|WMASK) & ~avail == 0.
  - If BARRIER: avail is all ones.
  - If the previous task had HOLD: that task's cores are no longer busy.
- States: IDLE, FETCH, WAIT, SEND, DONE.
- Reset (reset low):
  - State goes to IDLE.
  - Pointer = 0, busy = 0, hold record cleared, task_id = 0.
  - All outputs 0.
- IDLE: when prog_loading = 0 at a clock edge, go to FETCH.
- FETCH (one cycle):
  - Latch header, MASK and WMASK from frame P.
  - If the header frame == 0, or P >= DATA_DEPTH, go to DONE.
  - Otherwise go to WAIT.
- WAIT:
  - Evaluate the launch condition every cycle.
  - When it holds: pulse task_start, increment task_id, set busy for MASK.
  - Drive core_select = MASK, then go to SEND with index = P+3.
- SEND:
  - Each cycle with core_reading = 1: frame_out = frame[index], frame_being_sent = 1, index increments.
  - With core_reading = 0: stall. frame_being_sent = 0 and index holds.
  - After frame P+(LEN+1)*16-1 has been sent:
    - P advances by (LEN+1)*16.
    - core_select clears.
    - Go to FETCH.
  - A task running past DATA_DEPTH-1 is truncated at DATA_DEPTH-1, then goes to DONE.
- DONE: sched_done = 1 until prog_loading rises.
- prog_loading = 1 in any state: synchronously return to IDLE with pointer, busy and hold cleared.
- Outputs are registered. frame_being_sent coincides with valid frame_out.
- Simultaneous busy set and clear on the same core (launch edge): set wins.

Test Plan:
- Reset low for 5 cycles -> all outputs 0. Release with prog_loading = 1 -> stays in IDLE, no frames sent.
- Image with task0 = {0x0043, 0x000f, 0x000f} and core_ready = 0xffff, then drop prog_loading:
  - FETCH 1 cycle.
  - Launch: task_start pulse, core_select = 0x000f, task_id = 1.
  - 61 frames (frames 3..63) sent with frame_being_sent high.
- Task1 = {0x0003, 0x00f0, 0x00f0} after HOLD task0:
  - Holds in WAIT until core_ready[3:0] drops to 0 (0xfff0) and returns high (0xffff).
  - Then launches with core_select = 0x00f0.
- Task2 = {0x0007, 0x00f0, 0x00f0} while core_ready = 0xff0f:
  - Waits, because cores 4-7 are busy.
  - Launches after a 0->1 edge on core_ready[7:4].
  - Sends 125 frames (131..255).
- Task3 = {0x008f, 0x0f00, 0x0f00} with core_ready = 0xff0f:
  - No launch while the 0xff0f stall persists.
  - Launches only once core_ready = 0xffff and busy = 0.
  - After its last frame, sched_done = 1.
- core_reading toggling during SEND:
  - frame_being_sent follows core_reading.
  - No frame is skipped or duplicated: frame_out sequence is contiguous.

Source files
------------

// File: rtl/task_scheduler.sv
// task_scheduler: walks a preloaded program image and dispatches each task to
// a 16-core array.
//
// Each task starts with a 3-frame header:
//   frame P   : [5:0] LEN (span (LEN+1)*16 frames), [6] HOLD, [7] BARRIER
//   frame P+1 : MASK, the cores that run the task
//   frame P+2 : WMASK, extra cores that must be available before launch
// The remaining frames of the span are the task body.
//
// Handshake: core_reading acts as ready. On a clock edge where the scheduler
// is in SEND and core_reading is high, frame[index] is loaded into frame_out
// and frame_being_sent is set for the following cycle. With core_reading low,
// the bus stalls and index holds. A frame is never skipped or repeated.
//
// Ports:
//   clk, reset (async, active low), prog_loading (hold idle and clear)
//   data_frames_in  packed image; frame i is bits [i*FRAME_SIZE +: FRAME_SIZE]
//   core_ready      per-core idle flag
//   core_reading    cores accept the bus this cycle
//   frame_being_sent / frame_out   registered body frame and its valid flag
//   core_select     MASK of the running task
//   task_start      one-cycle launch pulse
//   task_id         launch counter
//   sched_done      image exhausted
//   dbg_state       current FSM state (IDLE=0 FETCH=1 WAIT=2 SEND=3 DONE=4)
module task_scheduler #(
  parameter int DATA_DEPTH  = 1024,
  parameter int INSTR_SIZE  = 16,
  parameter int FRAME_SIZE  = 16,
  parameter int CORE_NUM    = 16,
  parameter int BUS_TO_CORE = 16,
  parameter int R0_DEPTH    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             prog_loading,
  input  logic [DATA_DEPTH*FRAME_SIZE-1:0] data_frames_in,
  input  logic [CORE_NUM-1:0]              core_ready,
  input  logic                             core_reading,
  output logic                             frame_being_sent,
  output logic [BUS_TO_CORE-1:0]           frame_out,
  output logic [CORE_NUM-1:0]              core_select,
  output logic                             task_start,
  output logic [R0_DEPTH-1:0]              task_id,
  output logic                             sched_done,
  output logic [2:0]                       dbg_state
);

  localparam int AW = $clog2(DATA_DEPTH);
  // Two spare bits so pointer + span can exceed DATA_DEPTH without wrapping.
  localparam int PW = AW + 2;
  localparam logic [PW-1:0] DEPTH_P = PW'(DATA_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DATA_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          idx_q, idx_d;
  logic [PW-1:0]          end_q, end_d;
  logic [INSTR_SIZE-1:0]  hdr_q, hdr_d;
  logic [CORE_NUM-1:0]    mask_q, mask_d;
  logic [CORE_NUM-1:0]    wmask_q, wmask_d;
  logic [CORE_NUM-1:0]    busy_q, busy_d;
  logic [CORE_NUM-1:0]    ready_q;
  logic                   hold_q, hold_d;
  logic [CORE_NUM-1:0]    hold_mask_q, hold_mask_d;
  logic [BUS_TO_CORE-1:0] frame_out_q, frame_out_d;
  logic                   fbs_q, fbs_d;
  logic [CORE_NUM-1:0]    csel_q, csel_d;
  logic                   start_q, start_d;
  logic [R0_DEPTH-1:0]    tid_q, tid_d;
  logic                   done_q, done_d;

  logic [FRAME_SIZE-1:0] frames [DATA_DEPTH];
  for (genvar g = 0; g < DATA_DEPTH; g++) begin : g_unpack
    assign frames[g] = data_frames_in[g*FRAME_SIZE +: FRAME_SIZE];
  end

  // Out-of-range reads return zero, which also reads as an end-of-image header.
  function automatic logic [FRAME_SIZE-1:0] frame_at(input logic [PW-1:0] idx);
    frame_at = '0;
    if (idx < DEPTH_P) frame_at = frames[idx[AW-1:0]];
  endfunction

  function automatic logic [PW-1:0] span_of(input logic [5:0] len);
    span_of = PW'({1'b0, len} + 7'd1) << 4;
  endfunction

  logic [CORE_NUM-1:0]   rise, avail;
  logic [FRAME_SIZE-1:0] fetch_hdr;
  logic                  launch_ok;

  assign rise      = core_ready & ~ready_q;
  assign avail     = core_ready & ~busy_q;
  assign fetch_hdr = frame_at(ptr_q);
  assign launch_ok = (((mask_q | wmask_q) & ~avail) == '0)
                   && (!hdr_q[7] || (&avail))
                   && (!hold_q || ((hold_mask_q & busy_q) == '0));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    end_d       = end_q;
    hdr_d       = hdr_q;
    mask_d      = mask_q;
    wmask_d     = wmask_q;
    busy_d      = busy_q & ~rise;
    hold_d      = hold_q;
    hold_mask_d = hold_mask_q;
    frame_out_d = frame_out_q;
    fbs_d       = 1'b0;
    csel_d      = csel_q;
    start_d     = 1'b0;
    tid_d       = tid_q;
    done_d      = done_q;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        hdr_d   = fetch_hdr;
        mask_d  = frame_at(ptr_q + PW'(1));
        wmask_d = frame_at(ptr_q + PW'(2));
        end_d   = ptr_q + span_of(fetch_hdr[5:0]) - PW'(1);
        if (ptr_q >= DEPTH_P || fetch_hdr == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (launch_ok) begin
          start_d     = 1'b1;
          tid_d       = tid_q + R0_DEPTH'(1);
          busy_d      = busy_d | mask_q;   // a set on the launch edge wins
          csel_d      = mask_q;
          hold_d      = hdr_q[6];
          hold_mask_d = mask_q;
          idx_d       = ptr_q + PW'(3);
          state_d     = SEND;
        end
      end
      SEND: begin
        if (core_reading) begin
          frame_out_d = frame_at(idx_q);
          fbs_d       = 1'b1;
          idx_d       = idx_q + PW'(1);
          if (idx_q >= LAST_P && end_q > LAST_P) begin
            // Task overruns the image: stop at the last frame.
            csel_d  = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (idx_q == end_q) begin
            ptr_d   = end_q + PW'(1);
            csel_d  = '0;
            state_d = FETCH;
          end
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (prog_loading) begin
      state_d     = IDLE;
      ptr_d       = '0;
      busy_d      = '0;
      hold_d      = 1'b0;
      hold_mask_d = '0;
      csel_d      = '0;
      done_d      = 1'b0;
      fbs_d       = 1'b0;
      start_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      end_q       <= '0;
      hdr_q       <= '0;
      mask_q      <= '0;
      wmask_q     <= '0;
      busy_q      <= '0;
      ready_q     <= '0;
      hold_q      <= 1'b0;
      hold_mask_q <= '0;
      frame_out_q <= '0;
      fbs_q       <= 1'b0;
      csel_q      <= '0;
      start_q     <= 1'b0;
      tid_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      end_q       <= end_d;
      hdr_q       <= hdr_d;
      mask_q      <= mask_d;
      wmask_q     <= wmask_d;
      busy_q      <= busy_d;
      ready_q     <= core_ready;
      hold_q      <= hold_d;
      hold_mask_q <= hold_mask_d;
      frame_out_q <= frame_out_d;
      fbs_q       <= fbs_d;
      csel_q      <= csel_d;
      start_q     <= start_d;
      tid_q       <= tid_d;
      done_q      <= done_d;
    end
  end

  assign frame_being_sent = fbs_q;
  assign frame_out        = frame_out_q;
  assign core_select      = csel_q;
  assign task_start       = start_q;
  assign task_id          = tid_q;
  assign sched_done       = done_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_task_scheduler.sv
// Testbench for task_scheduler: four-task image exercising HOLD, busy
// tracking, BARRIER and the end-of-image header, with core_reading toggling
// throughout so body frames are sent with stalls.
module tb_task_scheduler;

  localparam int DD = 1024;
  localparam int FS = 16;
  localparam int CN = 16;
  localparam int RD = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic              clk;
  logic              reset;
  logic              prog_loading;
  logic [DD*FS-1:0]  data_frames_in;
  logic [CN-1:0]     core_ready;
  logic              core_reading;
  logic              frame_being_sent;
  logic [FS-1:0]     frame_out;
  logic [CN-1:0]     core_select;
  logic              task_start;
  logic [RD-1:0]     task_id;
  logic              sched_done;
  logic [2:0]        dbg_state;

  task_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .prog_loading     (prog_loading),
    .data_frames_in   (data_frames_in),
    .core_ready       (core_ready),
    .core_reading     (core_reading),
    .frame_being_sent (frame_being_sent),
    .frame_out        (frame_out),
    .core_select      (core_select),
    .task_start       (task_start),
    .task_id          (task_id),
    .sched_done       (sched_done),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int start_count = 0;
  logic [FS-1:0]      exp_q[$];        // expected body frames, in order
  logic [CN+RD-1:0]   exp_start_q[$];  // expected {core_select, task_id}
  logic               mon_en = 1'b0;
  logic               rd_en  = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [FS-1:0] body_val(input int i);
    body_val = 16'h8000 | FS'(i);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic build_image();
    data_frames_in = '0;
    for (int i = 0; i < 512; i++) data_frames_in[i*FS +: FS] = body_val(i);
    data_frames_in[0*FS +: FS]   = 16'h0043;  // LEN=3, HOLD
    data_frames_in[1*FS +: FS]   = 16'h000f;
    data_frames_in[2*FS +: FS]   = 16'h000f;
    data_frames_in[64*FS +: FS]  = 16'h0003;  // LEN=3
    data_frames_in[65*FS +: FS]  = 16'h00f0;
    data_frames_in[66*FS +: FS]  = 16'h00f0;
    data_frames_in[128*FS +: FS] = 16'h0007;  // LEN=7
    data_frames_in[129*FS +: FS] = 16'h00f0;
    data_frames_in[130*FS +: FS] = 16'h00f0;
    data_frames_in[256*FS +: FS] = 16'h008f;  // LEN=15, BARRIER
    data_frames_in[257*FS +: FS] = 16'h0f00;
    data_frames_in[258*FS +: FS] = 16'h0f00;
    // frame 512 stays zero: end of image
  endtask

  task automatic expect_body(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(body_val(i));
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    int n;
    n = 0;
    while (dbg_state !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dbg_state !== target) begin
      errors++;
      $display("FAIL %s: state %0d after %0d cycles, expected %0d", name, dbg_state, n, target);
    end
  endtask

  // core_reading pattern: two cycles on, one off, changed just after posedge.
  initial begin
    int cyc;
    cyc = 0;
    core_reading = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      core_reading = rd_en && (cyc % 3 != 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_send;
    logic prev_acc;
    logic [FS-1:0]    ef;
    logic [CN+RD-1:0] es;
    prev_send = 1'b0;
    prev_acc  = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_send) check("fbs_follows_reading", 32'(frame_being_sent), 32'(prev_acc));
        if (frame_being_sent) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_extra: got 0x%0h with no frame expected", frame_out);
          end else begin
            ef = exp_q.pop_front();
            check("frame_out", 32'(frame_out), 32'(ef));
          end
        end
        if (task_start) begin
          start_count++;
          if (exp_start_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL start_extra: got select 0x%0h id %0d with no launch expected",
                     core_select, task_id);
          end else begin
            es = exp_start_q.pop_front();
            check("launch_core_select", 32'(core_select), 32'(es[CN+RD-1:RD]));
            check("launch_task_id", 32'(task_id), 32'(es[RD-1:0]));
          end
        end
        prev_send = (dbg_state == S_SEND);
        prev_acc  = core_reading;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    reset        = 1'b0;
    prog_loading = 1'b1;
    core_ready   = '0;
    build_image();

    repeat (5) @(negedge clk);
    check("rst_frame_being_sent", 32'(frame_being_sent), 32'd0);
    check("rst_frame_out", 32'(frame_out), 32'd0);
    check("rst_core_select", 32'(core_select), 32'd0);
    check("rst_task_start", 32'(task_start), 32'd0);
    check("rst_task_id", 32'(task_id), 32'd0);
    check("rst_sched_done", 32'(sched_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);
    check("loading_state", 32'(dbg_state), 32'(S_IDLE));
    check("loading_no_frames", 32'(frame_being_sent), 32'd0);

    // Expected traffic for the whole image.
    expect_body(3, 63);
    expect_body(67, 127);
    expect_body(131, 255);
    expect_body(259, 511);
    exp_start_q.push_back({16'h000f, 8'd1});
    exp_start_q.push_back({16'h00f0, 8'd2});
    exp_start_q.push_back({16'h00f0, 8'd3});
    exp_start_q.push_back({16'h0f00, 8'd4});

    core_ready   = 16'hffff;
    rd_en        = 1'b1;
    prog_loading = 1'b0;
    @(negedge clk);
    check("t0_fetch", 32'(dbg_state), 32'(S_FETCH));
    @(negedge clk);
    check("t0_wait", 32'(dbg_state), 32'(S_WAIT));
    @(negedge clk);
    check("t0_send", 32'(dbg_state), 32'(S_SEND));
    check("t0_task_start", 32'(task_start), 32'd1);

    // Task 1 is held by task 0's HOLD until cores 0-3 report done.
    wait_state(S_WAIT, 400, "t1_reach_wait");
    repeat (10) @(negedge clk);
    check("t1_held_state", 32'(dbg_state), 32'(S_WAIT));
    check("t1_held_starts", 32'(start_count), 32'd1);
    core_ready = 16'hfff0;
    @(negedge clk);
    core_ready = 16'hffff;
    wait_state(S_SEND, 20, "t1_launch");

    // Task 2: cores 4-7 busy with task 1 and not ready.
    core_ready = 16'hff0f;
    wait_state(S_WAIT, 400, "t2_reach_wait");
    repeat (10) @(negedge clk);
    check("t2_held_state", 32'(dbg_state), 32'(S_WAIT));
    check("t2_held_starts", 32'(start_count), 32'd2);
    core_ready = 16'hffff;
    wait_state(S_SEND, 20, "t2_launch");

    // Task 3: barrier, blocked while cores 4-7 are stalled.
    core_ready = 16'hff0f;
    wait_state(S_WAIT, 600, "t3_reach_wait");
    repeat (10) @(negedge clk);
    check("t3_held_state", 32'(dbg_state), 32'(S_WAIT));
    check("t3_held_starts", 32'(start_count), 32'd3);
    core_ready = 16'hffff;
    wait_state(S_SEND, 20, "t3_launch");

    wait_state(S_DONE, 1000, "image_done");
    check("done_sched_done", 32'(sched_done), 32'd1);
    check("done_core_select", 32'(core_select), 32'd0);
    check("done_task_id", 32'(task_id), 32'd4);
    check("done_starts", 32'(start_count), 32'd4);
    check("done_frames_left", 32'(exp_q.size()), 32'd0);
    check("done_launches_left", 32'(exp_start_q.size()), 32'd0);

    prog_loading = 1'b1;
    @(negedge clk);
    check("reload_state", 32'(dbg_state), 32'(S_IDLE));
    check("reload_sched_done", 32'(sched_done), 32'd0);
    check("reload_task_id_kept", 32'(task_id), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
